// File: rtl/turfio_multisync_gen.sv
// Phase-locked sync marker generator with armed external SYNC pulse.
// Optional completed-sync statistics counter: TURFIO_MULTISYNC_STATS_EN.
module turfio_multisync_gen #(
    parameter int NCHAN       = 7,
    parameter int PERIOD_BITS = 4,
    parameter int COUNT_WIDTH = 48
) (
    input  logic                         sysclk_i,
    input  logic                         sysclk_rst_i,
    input  logic                         sync_req_i,
    input  logic                         en_ext_sync_i,
    input  logic [PERIOD_BITS-1:0]       sync_offset_i,
    input  logic [NCHAN*PERIOD_BITS-1:0] chan_offset_i,
    input  logic [NCHAN-1:0]             chan_en_i,
    output logic                         sync_o,
    output logic [NCHAN-1:0]             chan_sync_o,
    output logic                         ext_sync_o,
    output logic [COUNT_WIDTH-1:0]       sysclk_count_o,
    output logic                         sync_busy_o,
    output logic                         sync_done_o,
    output logic [15:0]                  sync_count_o
);

    localparam logic [PERIOD_BITS-1:0] PH_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARMED, PULSE} state_t;

    state_t                   state_q, state_d;
    logic [PERIOD_BITS-1:0]   phase_q, phase_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     sync_q, sync_d;
    logic [NCHAN-1:0]         chan_q, chan_d;
    logic                     ext_q, ext_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     clr_cnt;
    logic                     phase_max;
    logic [PERIOD_BITS-1:0]   tgt;

    assign phase_max = (phase_q == PH_MAX);
    assign phase_d   = phase_q + PERIOD_BITS'(1);

    // State register
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Next-state logic; abort on disable wins over the period boundary
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (sync_req_i && en_ext_sync_i) state_d = ARMED;
            ARMED: begin
                if (!en_ext_sync_i)  state_d = IDLE;
                else if (phase_max)  state_d = PULSE;
            end
            PULSE: if (phase_max) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode, registered below
    always_comb begin
        ext_d   = (state_d == PULSE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == PULSE) && phase_max;
        clr_cnt = (state_q == ARMED) && en_ext_sync_i && phase_max;
    end

    always_comb begin
        sync_d = (phase_q == sync_offset_i);
        chan_d = '0;
        tgt    = '0;
        for (int i = 0; i < NCHAN; i++) begin
            tgt       = sync_offset_i + chan_offset_i[i*PERIOD_BITS +: PERIOD_BITS];
            chan_d[i] = chan_en_i[i] && (phase_q == tgt);
        end
    end

    assign count_d = clr_cnt ? '0 : count_q + COUNT_WIDTH'(1);

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            phase_q <= '0;
            count_q <= '0;
            sync_q  <= 1'b0;
            chan_q  <= '0;
            ext_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
            sync_q  <= sync_d;
            chan_q  <= chan_d;
            ext_q   <= ext_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef TURFIO_MULTISYNC_STATS_EN
    logic [15:0] sync_count_q;

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i)
            sync_count_q <= '0;
        else if (done_d && sync_count_q != 16'hFFFF)
            sync_count_q <= sync_count_q + 16'd1;
    end

    assign sync_count_o = sync_count_q;
`else
    assign sync_count_o = '0;
`endif

    assign sync_o         = sync_q;
    assign chan_sync_o    = chan_q;
    assign ext_sync_o     = ext_q;
    assign sysclk_count_o = count_q;
    assign sync_busy_o    = busy_q;
    assign sync_done_o    = done_q;

endmodule

// File: tb/tb_turfio_multisync_gen.sv
// Directed bench for turfio_multisync_gen (default build plus 8-bit counter build).
module tb_turfio_multisync_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        en  = 1'b0;
    logic [3:0]  soff = 4'd3;
    logic [27:0] coff = 28'h00002F0;
    logic [6:0]  cen = 7'h05;

    logic        sync_o, ext_o, busy_o, done_o;
    logic [6:0]  chan_o;
    logic [47:0] cnt_o;
    logic [15:0] scnt_o;

    logic        sync8, ext8, busy8, done8;
    logic [6:0]  chan8;
    logic [7:0]  cnt8;
    logic [15:0] scnt8;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    longint cnt = 0;
    logic [15:0] exp_scnt;

    always #5 clk = ~clk;

    turfio_multisync_gen dut (
        .sysclk_i(clk), .sysclk_rst_i(rst), .sync_req_i(req),
        .en_ext_sync_i(en), .sync_offset_i(soff), .chan_offset_i(coff),
        .chan_en_i(cen), .sync_o(sync_o), .chan_sync_o(chan_o),
        .ext_sync_o(ext_o), .sysclk_count_o(cnt_o), .sync_busy_o(busy_o),
        .sync_done_o(done_o), .sync_count_o(scnt_o)
    );

    turfio_multisync_gen #(.COUNT_WIDTH(8)) dut8 (
        .sysclk_i(clk), .sysclk_rst_i(rst), .sync_req_i(req),
        .en_ext_sync_i(en), .sync_offset_i(soff), .chan_offset_i(coff),
        .chan_en_i(cen), .sync_o(sync8), .chan_sync_o(chan8),
        .ext_sync_o(ext8), .sysclk_count_o(cnt8), .sync_busy_o(busy8),
        .sync_done_o(done8), .sync_count_o(scnt8)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cnt++;
    endtask

    function automatic int ph();
        return cyc % 16;
    endfunction

    initial begin
`ifdef TURFIO_MULTISYNC_STATS_EN
        exp_scnt = 16'd1;
`else
        exp_scnt = 16'd0;
`endif
        // reset state
        tick(); tick();
        check("rst_sync", 64'(sync_o), 64'd0);
        check("rst_chan", 64'(chan_o), 64'd0);
        check("rst_ext", 64'(ext_o), 64'd0);
        check("rst_cnt", 64'(cnt_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_scnt", 64'(scnt_o), 64'd0);
        rst = 1'b0;
        cyc = 0;
        cnt = 0;

        // periodic global and per-channel markers
        for (int i = 0; i < 32; i++) begin
            int p;
            tick();
            p = (cyc - 1) % 16;
            check("sync_o", 64'(sync_o), 64'(p == 3));
            check("chan_sync", 64'(chan_o),
                  64'({p == 5, 1'b0, p == 3}));
            check("count", 64'(cnt_o), 64'(cnt));
        end

        // request with external sync disabled is ignored
        en = 1'b0;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("noen_busy", 64'(busy_o), 64'd0);
            check("noen_cnt", 64'(cnt_o), 64'(cnt));
            tick();
        end

        // full sync: arm at phase 5
        while (ph() != 5) tick();
        en = 1'b1;
        req = 1'b1;
        tick();
        req = 1'b0;
        check("arm_busy", 64'(busy_o), 64'd1);
        check("arm_ext", 64'(ext_o), 64'd0);
        while (ph() != 15) begin
            tick();
            check("armed_ext", 64'(ext_o), 64'd0);
        end
        tick();
        cnt = 0;
        check("clr_cnt", 64'(cnt_o), 64'd0);
        check("pulse_ext", 64'(ext_o), 64'd1);
        check("pulse_busy", 64'(busy_o), 64'd1);
        for (int i = 1; i < 16; i++) begin
            req = (i == 4);
            tick();
            check("pulse_ext_hold", 64'(ext_o), 64'd1);
            check("pulse_nodone", 64'(done_o), 64'd0);
        end
        req = 1'b0;
        check("pulse_cnt", 64'(cnt_o), 64'd15);
        tick();
        check("end_ext", 64'(ext_o), 64'd0);
        check("end_busy", 64'(busy_o), 64'd0);
        check("done", 64'(done_o), 64'd1);
        check("sync_count", 64'(scnt_o), 64'(exp_scnt));
        tick();
        check("done_one", 64'(done_o), 64'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("no_queue_busy", 64'(busy_o), 64'd0);
        end

        // abort by dropping enable at phase 10
        while (ph() != 2) tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        check("arm2_busy", 64'(busy_o), 64'd1);
        while (ph() != 10) tick();
        en = 1'b0;
        tick();
        check("abort_busy", 64'(busy_o), 64'd0);
        while (ph() != 0) begin
            tick();
            check("abort_ext", 64'(ext_o), 64'd0);
        end
        check("abort_cnt", 64'(cnt_o), 64'(cnt));
        tick();
        check("abort_done", 64'(done_o), 64'd0);
        check("abort_scnt", 64'(scnt_o), 64'(exp_scnt));

        // request at phase max waits a full period
        en = 1'b1;
        while (ph() != 15) tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        check("late_busy", 64'(busy_o), 64'd1);
        check("late_ext", 64'(ext_o), 64'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("late_wait_ext", 64'(ext_o), 64'd0);
        end
        tick();
        check("late_ext_on", 64'(ext_o), 64'd1);
        check("late_clr", 64'(cnt_o), 64'd0);
        tick(); tick(); tick();

        // reset mid-pulse
        rst = 1'b1;
        tick();
        check("mrst_sync", 64'(sync_o), 64'd0);
        check("mrst_chan", 64'(chan_o), 64'd0);
        check("mrst_ext", 64'(ext_o), 64'd0);
        check("mrst_cnt", 64'(cnt_o), 64'd0);
        check("mrst_busy", 64'(busy_o), 64'd0);
        check("mrst_done", 64'(done_o), 64'd0);
        check("mrst_scnt", 64'(scnt_o), 64'd0);
        check("mrst_cnt8", 64'(cnt8), 64'd0);
        rst = 1'b0;
        cyc = 0;
        cnt = 0;
        tick();
        check("post_rst_done", 64'(done_o), 64'd0);
        check("post_rst_ext", 64'(ext_o), 64'd0);

        // 8-bit counter wrap
        while (cyc < 255) tick();
        check("cnt8_max", 64'(cnt8), 64'd255);
        tick();
        check("cnt8_wrap", 64'(cnt8), 64'd0);
        check("cnt48_nowrap", 64'(cnt_o), 64'd256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
